// File: rtl/lsu_mem_if.sv
// Load/store unit: formats byte/half/word core accesses onto a valid/ready data bus and extends load data.
// Latency: store 2 stall cycles, load 3 (plus bus wait), decode error 1; rsp_valid pulses for one cycle.
// Backpressure: holds bus_* stable until bus_ready, stalls the core throughout; aborts after TIMEOUT_CYC. Macro: LSU_MISALIGN_TRAP_EN.
module lsu_mem_if #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [2:0]    req_func3,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          stall,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          err,
  output logic          bus_valid,
  input  logic          bus_ready,
  output logic          bus_we,
  output logic [3:0]    bus_be,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW         = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int TMO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CW-1:0] TMO_LAST = TMO_LAST_I[CW-1:0];

  logic [1:0]    state;
  logic          op_we;
  logic [2:0]    op_f3;
  logic [1:0]    op_off;
  logic [AW-3:0] addr_hi_q;
  logic [3:0]    be_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;

  logic [1:0]    dec_size;
  logic          dec_legal;
  logic          dec_err;
  logic [AW-1:0] dec_addr;
  logic [3:0]    dec_be;
  logic [DW-1:0] dec_wdata;
  logic [DW-1:0] ld_sh;
  logic [DW-1:0] ld_data;

  // func3[1:0] is the access size; loads also allow the unsigned byte/half forms.
  always_comb begin
    dec_size  = req_func3[1:0];
    dec_legal = req_we ? (!req_func3[2] && dec_size != 2'd3)
                       : (dec_size != 2'd3 && !(req_func3[2] && dec_size == 2'd2));
    dec_addr  = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    dec_err = !dec_legal
            || (dec_size == 2'd1 && req_addr[0])
            || (dec_size == 2'd2 && req_addr[1:0] != 2'b00);
`else
    dec_err = !dec_legal;
    if (dec_size == 2'd1) begin
      dec_addr[0] = 1'b0;
    end else if (dec_size == 2'd2) begin
      dec_addr[1:0] = 2'b00;
    end
`endif
    case (dec_size)
      2'd0: begin
        dec_be    = 4'b0001 << dec_addr[1:0];
        dec_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        dec_be    = 4'b0011 << {dec_addr[1], 1'b0};
        dec_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        dec_be    = 4'b1111;
        dec_wdata = req_wdata;
      end
    endcase
  end

  always_comb begin
    ld_sh = bus_rdata >> {op_off, 3'b000};
    case (op_f3)
      3'b000:  ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b100:  ld_data = {24'h0, ld_sh[7:0]};
      3'b001:  ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b101:  ld_data = {16'h0, ld_sh[15:0]};
      default: ld_data = bus_rdata;
    endcase
  end

  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt >= TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_we     <= 1'b0;
      op_f3     <= 3'b000;
      op_off    <= 2'b00;
      addr_hi_q <= '0;
      be_q      <= 4'b0000;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tmo_cnt <= '0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          if (req_valid) begin
            op_we     <= req_we;
            op_f3     <= req_func3;
            op_off    <= dec_addr[1:0];
            addr_hi_q <= dec_addr[AW-1:2];
            be_q      <= dec_be;
            wdata_q   <= dec_wdata;
            if (dec_err) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // An accepted request completes even on the last timeout cycle.
          if (bus_ready) begin
            state <= op_we ? S_DONE : S_WAIT;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end
          if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (bus_rvalid) begin
            rdata_q <= ld_data;
            state   <= S_DONE;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end
          if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Reset gates stall directly so the core is released while rst is low.
  assign stall     = rst && (((state == S_IDLE) && req_valid)
                           || (state == S_REQ) || (state == S_WAIT));
  assign rsp_valid = (state == S_DONE);
  assign rsp_rdata = rdata_q;
  assign err       = err_q;
  assign bus_valid = (state == S_REQ);
  assign bus_we    = op_we;
  assign bus_be    = be_q;
  assign bus_addr  = {addr_hi_q, 2'b00};
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: directed scenarios plus randomized accesses against a behavioural model.
module tb_lsu_mem_if;
  localparam int TMO = 8;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  lsu_mem_if #(.AW(32), .DW(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_be(bus_be),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One core access with a bus responder: ready after rdy_dly REQ cycles, rvalid after rv_dly WAIT cycles.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int rdy_dly, input int rv_dly,
                        output logic [31:0] o_rdata, output logic o_err, output int o_stall,
                        output logic [3:0] o_be, output logic [31:0] o_addr, output logic [31:0] o_wdata);
    int sz, v, nreq, nwait, stalls;
    bit legal, mis, early_err, tmo, exp_err, hs, done, seen;
    logic [31:0] ea, sh, exp_wd, exp_ld, exp_rd;
    logic [3:0] exp_be;
    int exp_stall;

    sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = (addr % sz) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    early_err = !legal || mis;
    ea = addr;
`else
    early_err = !legal;
    ea = addr - (addr % sz);
`endif
    if (sz == 4) exp_be = 4'hF;
    else if (sz == 2) exp_be = 4'h3 << (ea % 4);
    else exp_be = 4'h1 << (ea % 4);
    if (sz == 1) exp_wd = wdata[7:0] * 32'h0101_0101;
    else if (sz == 2) exp_wd = wdata[15:0] * 32'h0001_0001;
    else exp_wd = wdata;
    sh = rdata >> (8 * (ea % 4));
    case (f3)
      3'd0: begin v = int'(sh & 32'hFF); if (v >= 128) v -= 256; exp_ld = 32'(v); end
      3'd4: exp_ld = sh & 32'hFF;
      3'd1: begin v = int'(sh & 32'hFFFF); if (v >= 32768) v -= 65536; exp_ld = 32'(v); end
      3'd5: exp_ld = sh & 32'hFFFF;
      default: exp_ld = rdata;
    endcase
    tmo       = !early_err && ((rdy_dly + 1 > TMO) || (!we && rdy_dly + rv_dly + 2 > TMO));
    exp_err   = early_err || tmo;
    exp_rd    = (exp_err || we) ? 32'h0 : exp_ld;
    exp_stall = early_err ? 1 : tmo ? 1 + TMO : we ? rdy_dly + 2 : rdy_dly + rv_dly + 3;

    hs = 0; done = 0; seen = 0; nreq = 0; nwait = 0; stalls = 0;
    o_rdata = '0; o_err = 1'b0; o_be = '0; o_addr = '0; o_wdata = '0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata;
      if (bus_valid) begin
        seen = 1;
        o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata;
        chk("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
        chk("bus_be", {28'h0, bus_be}, {28'h0, exp_be});
        chk("bus_we", {31'h0, bus_we}, {31'h0, we});
        if (we) chk("bus_wdata", bus_wdata, exp_wd);
        bus_ready  = (nreq == rdy_dly);
        if (bus_ready) hs = 1;
        nreq++;
        bus_rvalid = 1'($urandom % 2);
        bus_rdata  = $urandom;
      end else if (hs) begin
        bus_ready  = 1'($urandom % 2);
        bus_rvalid = (nwait == rv_dly);
        bus_rdata  = bus_rvalid ? rdata : $urandom;
        nwait++;
      end else begin
        bus_ready  = 1'($urandom % 2);
        bus_rvalid = 1'($urandom % 2);
        bus_rdata  = $urandom;
      end
      #1;
      if (stall) stalls++;
      if (rsp_valid) begin
        done = 1;
        o_err = err; o_rdata = rsp_rdata;
        req_valid = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
      end
    end
    chk("rsp_seen", {31'h0, done}, 32'h1);
    chk("err", {31'h0, o_err}, {31'h0, exp_err});
    chk("rsp_rdata", o_rdata, exp_rd);
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    chk("bus_used", {31'h0, seen}, {31'h0, !early_err});
    o_stall = stalls;
  endtask

  initial begin
    logic [31:0] rd, wd;
    logic        e;
    int          st;
    logic [3:0]  be;
    logic [31:0] ba;

    rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'd2; req_addr = 32'h0;
    req_wdata = 32'h0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_be", {28'h0, bus_be}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);

    // SW aligned, bus ready immediately
    access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, rd, e, st, be, ba, wd);
    chk("t1_be", {28'h0, be}, 32'hF);
    chk("t1_addr", ba, 32'h100);
    chk("t1_stall", 32'(st), 32'd2);
    chk("t1_err", {31'h0, e}, 32'h0);

    // SB to top byte lane
    access(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0, rd, e, st, be, ba, wd);
    chk("t2_be", {28'h0, be}, 32'h8);
    chk("t2_wdata", wd, 32'hA5A5_A5A5);

    // LB / LBU with three idle wait cycles
    access(1'b0, 3'b000, 32'h102, 32'h0, 32'h1280_5634, 0, 3, rd, e, st, be, ba, wd);
    chk("t3_lb", rd, 32'hFFFF_FF80);
    chk("t3_lb_stall", 32'(st), 32'd6);
    access(1'b0, 3'b100, 32'h102, 32'h0, 32'h1280_5634, 0, 3, rd, e, st, be, ba, wd);
    chk("t3_lbu", rd, 32'h0000_0080);
    chk("t3_lbu_stall", 32'(st), 32'd6);

    // Misaligned LH
    access(1'b0, 3'b001, 32'h101, 32'h0, 32'h8765_4321, 1, 0, rd, e, st, be, ba, wd);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("t4_err", {31'h0, e}, 32'h1);
    chk("t4_rdata", rd, 32'h0);
    chk("t4_stall", 32'(st), 32'd1);
`else
    chk("t4_err", {31'h0, e}, 32'h0);
    chk("t4_be", {28'h0, be}, 32'h3);
    chk("t4_addr", ba, 32'h100);
    chk("t4_rdata", rd, 32'h0000_4321);
`endif

    // Illegal func3 store, then bus never answers: timeout
    access(1'b1, 3'b100, 32'h104, 32'h1234_5678, 32'h0, 0, 0, rd, e, st, be, ba, wd);
    chk("illegal_err", {31'h0, e}, 32'h1);
    access(1'b0, 3'b010, 32'h104, 32'h0, 32'h5555_AAAA, 100, 0, rd, e, st, be, ba, wd);
    chk("t5_err", {31'h0, e}, 32'h1);
    chk("t5_rdata", rd, 32'h0);
    chk("t5_stall", 32'(st), 32'(1 + TMO));
    access(1'b0, 3'b010, 32'h108, 32'h0, 32'hCAFE_F00D, 1, 1, rd, e, st, be, ba, wd);
    chk("t5_next_rdata", rd, 32'hCAFE_F00D);
    chk("t5_next_err", {31'h0, e}, 32'h0);

    // Async reset while waiting for read data
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h200;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    chk("t6_in_req", {31'h0, bus_valid}, 32'h1);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    chk("t6_wait_stall", {31'h0, stall}, 32'h1);
    rst = 1'b0;
    #1;
    chk("t6_rst_bus_valid", {31'h0, bus_valid}, 32'h0);
    chk("t6_rst_stall", {31'h0, stall}, 32'h0);
    chk("t6_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    bus_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t6_stray_rsp", {31'h0, rsp_valid}, 32'h0);
      chk("t6_stray_bus", {31'h0, bus_valid}, 32'h0);
    end
    access(1'b0, 3'b010, 32'h204, 32'h0, 32'h1357_9BDF, 0, 0, rd, e, st, be, ba, wd);
    chk("t6_after_stall", 32'(st), 32'd3);
    chk("t6_after_rdata", rd, 32'h1357_9BDF);

    // Randomized accesses; latencies kept inside the timeout window
    for (int n = 0; n < 60; n++) begin
      access(1'($urandom % 2), 3'($urandom_range(0, 7)), 32'h1000 + $urandom_range(0, 255),
             $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
             rd, e, st, be, ba, wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
